// File: rtl/dispatch_arbiter_if.sv
// Handshake bundle between the instruction source, the dispatcher
// and the per-core FIFO consumers.
interface dispatch_arbiter_if #(
    parameter int NUM_CORES = 2,
    parameter int DEPTH     = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]             instr_in;
    logic                    instr_valid;
    logic                    instr_ready;
    logic [NUM_CORES*32-1:0] fifo_out;
    logic [NUM_CORES-1:0]    fifo_valid;
    logic [NUM_CORES-1:0]    fifo_ready;
    logic [NUM_CORES*CW-1:0] fifo_count;
    logic                    stall_hazard;

    modport master (
        output instr_in, instr_valid, fifo_ready,
        input  instr_ready, fifo_out, fifo_valid,
        input  fifo_count, stall_hazard
    );

    modport slave (
        input  instr_in, instr_valid, fifo_ready,
        output instr_ready, fifo_out, fifo_valid,
        output fifo_count, stall_hazard
    );
endinterface

// File: rtl/dispatch_arbiter.sv
// Hazard-aware dispatcher: steers one instruction stream into
// NUM_CORES show-ahead FIFOs, co-locating dependent instructions.
module dispatch_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int DEPTH     = 8
) (
    input  logic clk,
    input  logic reset,
    dispatch_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(NUM_CORES);

    logic [31:0]          mem    [NUM_CORES][DEPTH];
    logic [AW-1:0]        rd_ptr [NUM_CORES];
    logic [AW-1:0]        wr_ptr [NUM_CORES];
    logic [CW-1:0]        cnt    [NUM_CORES];
    logic [IW-1:0]        rr_ptr;

    logic [NUM_CORES-1:0] full;
    logic [NUM_CORES-1:0] conf;
    logic [NUM_CORES-1:0] push;
    logic [NUM_CORES-1:0] pop;
    logic [2:0]           n_conf;
    logic [IW-1:0]        tgt;
    logic                 has_tgt;
    logic                 rr_sel;
    logic                 rdy;
    logic                 accept;
    logic                 unused_bits;

    assign unused_bits = ^{bus.instr_in[31:28], bus.instr_in[26],
                           bus.instr_in[24]};

    // Register-level dependency between incoming word i and queued word e.
    function automatic logic hazard(input logic [31:0] i,
                                    input logic [31:0] e);
        logic i_src, i_dst, e_src, e_dst;
        i_src = !i[23];
        i_dst = !i[22];
        e_src = !e[23];
        e_dst = !e[22];
        return (i_src && e_dst && i[10:0]  == e[21:11]) ||
               (i_dst && e_src && i[21:11] == e[10:0])  ||
               (i_dst && e_dst && i[21:11] == e[21:11]);
    endfunction

    // Distance of slot k from the head, modulo DEPTH.
    function automatic logic [AW-1:0] slot_off(input logic [AW-1:0] k,
                                               input logic [AW-1:0] r);
        return k - r;
    endfunction

    // Scan only live slots of every FIFO for conflicts with instr_in.
    always_comb begin
        conf   = '0;
        full   = '0;
        n_conf = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            full[c] = (cnt[c] == CW'(DEPTH));
            for (int k = 0; k < DEPTH; k++) begin
                if ({1'b0, slot_off(AW'(k), rd_ptr[c])} < cnt[c] &&
                    hazard(bus.instr_in, mem[c][k]))
                    conf[c] = 1'b1;
            end
            n_conf = n_conf + 3'(conf[c]);
        end
    end

    // Target selection: forced, single conflict, stall, else round-robin.
    always_comb begin
        tgt     = '0;
        has_tgt = 1'b0;
        rr_sel  = 1'b0;
        if (bus.instr_in[27]) begin
            tgt = bus.instr_in[25 +: IW];
            for (int c = 0; c < NUM_CORES; c++)
                if (IW'(c) == tgt)
                    has_tgt = 1'b1;
        end else if (n_conf == 3'd1) begin
            for (int c = 0; c < NUM_CORES; c++) begin
                if (conf[c]) begin
                    tgt     = IW'(c);
                    has_tgt = 1'b1;
                end
            end
        end else if (n_conf == 3'd0) begin
            rr_sel = 1'b1;
            for (int k = NUM_CORES - 1; k >= 0; k--) begin
                if (!full[(int'(rr_ptr) + k) % NUM_CORES]) begin
                    tgt     = IW'((int'(rr_ptr) + k) % NUM_CORES);
                    has_tgt = 1'b1;
                end
            end
        end
        rdy = !reset && has_tgt && !full[tgt];
    end

    assign accept           = bus.instr_valid && rdy;
    assign bus.instr_ready  = rdy;
    assign bus.stall_hazard = !reset && bus.instr_valid &&
                              !bus.instr_in[27] && (n_conf >= 3'd2);

    // Per-FIFO push/pop strobes and show-ahead outputs.
    always_comb begin
        push           = '0;
        pop            = '0;
        bus.fifo_valid = '0;
        bus.fifo_out   = '0;
        bus.fifo_count = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            push[c]              = accept && (tgt == IW'(c));
            pop[c]               = (cnt[c] != '0) && bus.fifo_ready[c];
            bus.fifo_valid[c]    = (cnt[c] != '0);
            bus.fifo_count[c*CW +: CW] = cnt[c];
            if (cnt[c] != '0)
                bus.fifo_out[c*32 +: 32] = mem[c][rd_ptr[c]];
        end
    end

    // Storage write; push is already blocked while reset is high.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CORES; c++)
            if (push[c])
                mem[c][wr_ptr[c]] <= bus.instr_in;
    end

    // Pointers, occupancy and round-robin state.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            for (int c = 0; c < NUM_CORES; c++) begin
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                cnt[c]    <= '0;
            end
        end else begin
            if (accept && rr_sel)
                rr_ptr <= IW'((int'(tgt) + 1) % NUM_CORES);
            for (int c = 0; c < NUM_CORES; c++) begin
                if (push[c])
                    wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (pop[c])
                    rd_ptr[c] <= rd_ptr[c] + 1'b1;
                if (push[c] && !pop[c])
                    cnt[c] <= cnt[c] + 1'b1;
                else if (pop[c] && !push[c])
                    cnt[c] <= cnt[c] - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dispatch_arbiter.sv
// Scoreboard bench for dispatch_arbiter: expected words are queued per
// core at dispatch and compared against fifo_out when popped.
module tb_dispatch_arbiter;
    localparam int NC = 2;
    localparam int DP = 4;
    localparam int CW = $clog2(DP) + 1;

    logic clk = 1'b0;
    logic reset;

    dispatch_arbiter_if #(.NUM_CORES(NC), .DEPTH(DP)) bus ();

    dispatch_arbiter #(.NUM_CORES(NC), .DEPTH(DP)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_q [NC][$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    // One cycle of stimulus: present word/pops, check ready/stall/heads.
    task automatic cyc(input logic v, input logic [31:0] w, input int core,
                       input logic ok, input logic stl,
                       input logic [NC-1:0] pm);
        @(negedge clk);
        bus.instr_valid = v;
        bus.instr_in    = w;
        bus.fifo_ready  = pm;
        #1;
        if (v) begin
            check("instr_ready", 32'(bus.instr_ready), 32'(ok));
            check("stall_hazard", 32'(bus.stall_hazard), 32'(stl));
        end
        for (int c = 0; c < NC; c++) begin
            if (pm[c]) begin
                if (exp_q[c].size() > 0) begin
                    check("fifo_valid", 32'(bus.fifo_valid[c]), 32'd1);
                    check("head", bus.fifo_out[c*32 +: 32],
                          exp_q[c].pop_front());
                end else begin
                    check("empty_valid", 32'(bus.fifo_valid[c]), 32'd0);
                end
            end
        end
        if (v && ok)
            exp_q[core].push_back(w);
    endtask

    task automatic send(input logic [31:0] w, input int core);
        cyc(1'b1, w, core, 1'b1, 1'b0, '0);
    endtask

    task automatic popm(input logic [NC-1:0] pm);
        cyc(1'b0, 32'h0, 0, 1'b0, 1'b0, pm);
    endtask

    // Idle cycle, then occupancy / empty-output checks.
    task automatic chk(input int c0, input int c1);
        int cc [NC];
        cc[0] = c0;
        cc[1] = c1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.fifo_ready  = '0;
        #1;
        for (int c = 0; c < NC; c++) begin
            check("fifo_count", 32'(bus.fifo_count[c*CW +: CW]), 32'(cc[c]));
            check("fifo_valid", 32'(bus.fifo_valid[c]), 32'(cc[c] != 0));
            if (cc[c] == 0)
                check("fifo_out_zero", bus.fifo_out[c*32 +: 32], 32'h0);
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr_in    = 32'h00C0_0001;
        bus.fifo_ready  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", 32'(bus.instr_ready), 32'd0);
        check("rst_stall", 32'(bus.stall_hazard), 32'd0);
        check("rst_count", 32'(bus.fifo_count), 32'd0);
        check("rst_valid", 32'(bus.fifo_valid), 32'd0);
        check("rst_out0", bus.fifo_out[31:0], 32'h0);
        check("rst_out1", bus.fifo_out[63:32], 32'h0);
        bus.instr_valid = 1'b0;
        reset = 1'b0;

        // Independent stream alternates 0,1,0,1.
        for (int k = 0; k < 4; k++)
            send(32'h00C0_0010 + 32'(k), k % 2);
        chk(2, 2);
        popm(2'b11);
        popm(2'b11);
        chk(0, 0);

        // Dependent instruction follows its producer to core 0.
        send(32'h0000_0805, 0);
        send(32'h0040_0001, 0);
        send(32'h00C0_0077, 1);
        chk(2, 1);
        popm(2'b11);
        popm(2'b01);
        popm(2'b11);
        chk(0, 0);

        // Two-core conflict stalls until core 1 drains.
        send(32'h0080_0800, 0);
        send(32'h0080_1000, 1);
        cyc(1'b1, 32'h0000_1001, 0, 1'b0, 1'b1, 2'b00);
        cyc(1'b1, 32'h0000_1001, 0, 1'b0, 1'b1, 2'b10);
        cyc(1'b1, 32'h0000_1001, 0, 1'b1, 1'b0, 2'b00);
        chk(2, 0);

        // Forced to core 1 despite conflict; round-robin untouched.
        send(32'h0A00_0001, 1);
        send(32'h00C0_00AA, 0);
        chk(3, 1);
        popm(2'b11);
        popm(2'b01);
        popm(2'b01);
        chk(0, 0);

        // Full core 0 blocks a conflict-steered push until a pop lands.
        send(32'h0880_1801, 0);
        send(32'h0880_1802, 0);
        send(32'h08C0_0013, 0);
        send(32'h08C0_0014, 0);
        chk(4, 0);
        cyc(1'b1, 32'h0040_0003, 0, 1'b0, 1'b0, 2'b00);
        cyc(1'b1, 32'h0040_0003, 0, 1'b0, 1'b0, 2'b01);
        cyc(1'b1, 32'h0040_0003, 0, 1'b1, 1'b0, 2'b00);
        chk(4, 0);
        for (int k = 0; k < 4; k++)
            popm(2'b01);
        chk(0, 0);

        // Mid-operation reset flushes and restarts round-robin at core 0.
        send(32'h00C0_0101, 1);
        send(32'h00C0_0102, 0);
        send(32'h00C0_0103, 1);
        chk(1, 2);
        @(negedge clk);
        reset           = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr_in    = 32'h00C0_0104;
        bus.fifo_ready  = 2'b11;
        #1;
        check("mid_rst_ready", 32'(bus.instr_ready), 32'd0);
        @(negedge clk);
        reset           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.fifo_ready  = '0;
        for (int c = 0; c < NC; c++)
            exp_q[c].delete();
        #1;
        check("flush_count", 32'(bus.fifo_count), 32'd0);
        check("flush_out", bus.fifo_out[31:0] | bus.fifo_out[63:32], 32'h0);
        send(32'h00C0_0201, 0);
        send(32'h00C0_0202, 1);
        chk(1, 1);
        popm(2'b11);
        chk(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dispatch_arbiter.md
# dispatch_arbiter

Parametrised instruction dispatcher that steers a single incoming instruction stream into NUM_CORES per-core FIFOs feeding the pipelined cores of the multicore processor. It checks operand hazards against every instruction still queued. Dependent instructions are co-located on the core that already holds their producer or consumer, and independent instructions are spread round-robin. Unlike the previous two-queue arbiter, it is clocked, has valid/ready flow control on both sides, compares only against valid queue entries, and stalls rather than dropping or mis-steering an instruction.

## Interface
- NUM_CORES, 2: number of cores/FIFOs; legal 2..4
- DEPTH, 8: entries per FIFO; power of two, >= 2
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instr_in  in  32  instruction word
- instr_valid  in  1  instr_in is valid
- instr_ready  out  1  arbiter accepts instr_in this cycle
- fifo_out  out  NUM_CORES*32  head entry of each FIFO; core c uses bits [32c+31:32c]
- fifo_valid  out  NUM_CORES  FIFO c is non-empty
- fifo_ready  in  NUM_CORES  core c pops its head this cycle
- fifo_count  out  NUM_CORES*($clog2(DEPTH)+1)  occupancy per FIFO
- stall_hazard  out  1  high while a valid instruction is held off by a multi-core conflict

## Operation
- Instruction fields:
  - [27] force bit.
  - [26:25] forced core id; only the low $clog2(NUM_CORES) bits are used.
  - [23] src mode; 0 means register-tracked.
  - [22] dest mode; 0 means register-tracked.
  - [21:11] dest address.
  - [10:0] src address.
- Conflict between incoming instruction I and a queued valid entry E. Any of the following is a conflict:
  - I.src tracked, E.dest tracked, and I.src == E.dest.
  - I.dest tracked, E.src tracked, and I.dest == E.src.
  - I.dest and E.dest both tracked, and I.dest == E.dest.
- Untracked operands never conflict. Empty or popped slots never conflict.
- conf[c] = I conflicts with at least one valid entry of FIFO c.
- Target selection for a valid instruction, in priority order:
  - Force bit = 1: target is the forced core id. The hazard check is bypassed.
  - Exactly one conf[c] set: target is c.
  - Two or more conf[c] set: no target; stall_hazard = 1.
  - No conf[c] set: target is the first non-full FIFO searching from rr_ptr upward, with wrap.
- Acceptance: instr_ready = !reset and a target exists and the target FIFO is not full. The handshake is instr_valid && instr_ready. instr_ready may depend combinationally on instr_in.
- "Full" uses the registered count == DEPTH. A simultaneous pop does not free space for a push in the same cycle.
- rr_ptr advances to (target+1) mod NUM_CORES only on an accepted round-robin dispatch. Forced and conflict-steered dispatches leave rr_ptr unchanged.
- FIFOs are show-ahead: fifo_out[c] is the head entry, and is 0 when fifo_valid[c] = 0.
- A pop occurs when fifo_valid[c] && fifo_ready[c]. fifo_ready while empty is ignored.
- A simultaneous push and pop on the same non-full FIFO leaves the count unchanged and preserves order.
- The hazard scan uses FIFO contents at the start of the cycle. An entry popped in the same cycle still counts as a conflict.
- Entries already popped by a core are not tracked. The downstream cores own hazards on issued instructions.

## Timing
- Reset values: all fifo_count = 0, fifo_valid = 0, fifo_out = 0, rr_ptr = 0, instr_ready = 0, stall_hazard = 0. Storage contents are don't-care but must be unreadable while empty.
- Reset asserted mid-operation flushes all queued entries on the next clock edge. Any in-flight handshake in that cycle is not accepted.
- Latency: an instruction accepted at edge N into an empty FIFO gives fifo_valid = 1 with that word on fifo_out after edge N.
- Throughput: one instruction per cycle while targets have space.
- stall_hazard is combinational and asserts in the same cycle as the blocked instruction. It deasserts the cycle after conflicts drop to at most one core.
- Pointer wrap: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by count, not by pointer comparison.

## Test plan
- Reset, then 4 independent instructions (all with [23:22] = 2'b11) into NUM_CORES = 2 → dispatched to cores 0,1,0,1; fifo_count = 2,2; instr_ready never drops.
- Queue 0x0000_0805 (dest 1, src 5, both tracked) to core 0, then an instruction with src = 1 → second goes to core 0 even though rr_ptr points to core 1.
- Core 0 holds dest 1 and core 1 holds dest 2; send src = 1, dest = 2 → instr_ready = 0 and stall_hazard = 1. Pop core 1 → accepted into core 0 the cycle after the pop.
- Forced instruction ([27] = 1, [25] = 1) that conflicts with core 0 → lands in core 1 and rr_ptr is unchanged.
- DEPTH = 4 with core 0 full and fifo_ready = 0; a conflict-steered instruction to core 0 stalls. Assert fifo_ready[0] for one cycle → push accepted the following cycle; count returns to 4; head order is preserved.
- Assert reset with both FIFOs partially full → next cycle all counts = 0 and fifo_out = 0. Data sent after reset is dispatched starting at core 0.
